// File: rtl/xor_share_pkg.sv
// ---------------------------------------------------------------------------
// xor_share_pkg
// Shared definitions for the bit-serial XOR scheduler.
//   N_REQ_DEF  : default number of requesters sharing the XOR cell
//   WIDTH_DEF  : default operand/result width in bits
//   IDX_W_DEF  : width of a requester index for the default N_REQ
//   state_e    : scheduler FSM states (IDLE, SHIFT, HOLD)
// ---------------------------------------------------------------------------
package xor_share_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int WIDTH_DEF = 8;
   localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/xor_bit_cell.sv
// ---------------------------------------------------------------------------
// xor_bit_cell
// The single shared 1-bit XOR cell. Every result bit the scheduler produces
// passes through this one gate.
// Ports:
//   a : operand A bit
//   b : operand B bit
//   f : a XOR b
// ---------------------------------------------------------------------------
module xor_bit_cell (
   input  logic a,
   input  logic b,
   output logic f
);

   xor uXor (f, a, b);

endmodule

// File: rtl/xor_share_sched.sv
// ---------------------------------------------------------------------------
// xor_share_sched
// Round-robin scheduler that time-shares one 1-bit XOR cell between N_REQ
// requesters. A granted request is processed bit-serially, LSB first, one
// bit per cycle, and the result is then held until the consumer accepts it.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : per-requester request level, held until gnt
//   req_a      : packed operand A, requester i in [i*WIDTH +: WIDTH]
//   req_b      : packed operand B, same packing as req_a
//   gnt        : one-hot accept pulse, one cycle per transaction
//   busy       : high whenever the FSM is not IDLE
//   res_valid  : result available (HOLD state)
//   res_data   : A XOR B of the served request
//   res_id     : index of the served requester
//   res_ready  : consumer accepts the result
// ---------------------------------------------------------------------------
module xor_share_sched
   import xor_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*WIDTH-1:0]     req_a,
   input  logic [N_REQ*WIDTH-1:0]     req_b,
   output logic [N_REQ-1:0]           gnt,
   output logic                       busy,
   output logic                       res_valid,
   output logic [WIDTH-1:0]           res_data,
   output logic [$clog2(N_REQ)-1:0]   res_id,
   input  logic                       res_ready
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   opA_q,   opA_d;
   logic [WIDTH-1:0]   opB_q,   opB_d;
   logic [WIDTH-1:0]   res_q,   res_d;
   logic [IDX_W-1:0]   id_q,    id_d;
   logic [IDX_W-1:0]   last_q,  last_d;

   logic               winFound;
   logic [IDX_W-1:0]   winIdx;
   logic               cellA;
   logic               cellB;
   logic               cellF;

   // The shared XOR cell always looks at the operand bit selected by the
   // bit counter; its output is only captured while in SHIFT.
   assign cellA = opA_q[cnt_q];
   assign cellB = opB_q[cnt_q];

   xor_bit_cell uCell (
      .a (cellA),
      .b (cellB),
      .f (cellF)
   );

   // Round-robin search: walk upward from the requester after the last
   // winner, wrapping around, and take the first one asking. Starting at
   // last+1 and ending at last itself gives every requester a turn before
   // anyone is served twice.
   always_comb begin
      logic [IDX_W-1:0] cand;
      winFound = 1'b0;
      winIdx   = '0;
      cand     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % N_REQ);
         if (!winFound && req[cand]) begin
            winFound = 1'b1;
            winIdx   = cand;
         end
      end
   end

   // State register for the scheduler FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and grant decode. The grant cycle is the IDLE cycle in which
   // a winner exists, so gnt is a decode of the registered state and can only
   // ever be one-hot for a single cycle. It is held low while reset is
   // asserted so a waiting request cannot be granted into a block that is
   // not going to accept it. Operands and the winner index are captured on
   // that same edge; requests arriving later simply wait in IDLE's next
   // search, and the pointer only moves when a grant is actually issued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      res_d   = res_q;
      id_d    = id_q;
      last_d  = last_q;
      gnt     = '0;
      unique case (state_q)
         IDLE: begin
            if (winFound && !rst) begin
               gnt[winIdx] = 1'b1;
               opA_d       = req_a[int'(winIdx)*WIDTH +: WIDTH];
               opB_d       = req_b[int'(winIdx)*WIDTH +: WIDTH];
               id_d        = winIdx;
               last_d      = winIdx;
               cnt_d       = '0;
               res_d       = '0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            res_d[cnt_q] = cellF;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath registers. Reset clears everything and parks the round-robin
   // pointer on the last requester so requester 0 is served first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         opA_q  <= '0;
         opB_q  <= '0;
         res_q  <= '0;
         id_q   <= '0;
         last_q <= IDX_W'(N_REQ - 1);
      end else begin
         cnt_q  <= cnt_d;
         opA_q  <= opA_d;
         opB_q  <= opB_d;
         res_q  <= res_d;
         id_q   <= id_d;
         last_q <= last_d;
      end
   end

   // Status outputs are pure decodes of the registered state.
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == HOLD);
   assign res_data  = res_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_xor_share_sched.sv
// ---------------------------------------------------------------------------
// tb_xor_share_sched
// Directed bench for the bit-serial XOR scheduler with hand-computed
// expected values. Inputs change 2 time units after the rising edge and
// outputs are sampled 1 time unit later, well away from the clock edge.
// ---------------------------------------------------------------------------
module tb_xor_share_sched;
   import xor_share_pkg::*;

   logic                  clk;
   logic                  rst;
   logic [3:0]            req;
   logic [31:0]           req_a;
   logic [31:0]           req_b;
   logic [3:0]            gnt;
   logic                  busy;
   logic                  res_valid;
   logic [7:0]            res_data;
   logic [IDX_W_DEF-1:0]  res_id;
   logic                  res_ready;

   int checks;
   int errors;

   logic [3:0] expGntSeq  [5];
   logic [7:0] expDataSeq [5];
   logic [1:0] expIdSeq   [5];

   xor_share_sched #(
      .N_REQ (4),
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .gnt       (gnt),
      .busy      (busy),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to 2 units past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Drive all data inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] a,
                                input logic [31:0] b, input logic rdy);
      req       = r;
      req_a     = a;
      req_b     = b;
      res_ready = rdy;
      #1;
   endtask

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // A complete single transaction with ready held high. Starts in an IDLE
   // cycle T and returns in cycle T+10, back in IDLE with req low.
   task automatic runOne(input string tag, input logic [3:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] expGnt, input logic [7:0] expData,
                         input logic [1:0] expId);
      applyStimulus(r, a, b, 1'b1);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'(expGnt));
      checkOutput({tag, "_busyT"}, 32'(busy), 32'd0);
      tick();
      applyStimulus(4'b0000, a, b, 1'b1);
      checkOutput({tag, "_gntT1"}, 32'(gnt), 32'd0);
      checkOutput({tag, "_busyT1"}, 32'(busy), 32'd1);
      repeat (7) tick();
      checkOutput({tag, "_validT8"}, 32'(res_valid), 32'd0);
      tick();
      checkOutput({tag, "_validT9"}, 32'(res_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(res_data), 32'(expData));
      checkOutput({tag, "_id"}, 32'(res_id), 32'(expId));
      tick();
      checkOutput({tag, "_validT10"}, 32'(res_valid), 32'd0);
      checkOutput({tag, "_busyT10"}, 32'(busy), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;

      expGntSeq[0] = 4'b0001; expIdSeq[0] = 2'd0; expDataSeq[0] = 8'h0E;
      expGntSeq[1] = 4'b0010; expIdSeq[1] = 2'd1; expDataSeq[1] = 8'hC3;
      expGntSeq[2] = 4'b0100; expIdSeq[2] = 2'd2; expDataSeq[2] = 8'h5A;
      expGntSeq[3] = 4'b1000; expIdSeq[3] = 2'd3; expDataSeq[3] = 8'hFF;
      expGntSeq[4] = 4'b0001; expIdSeq[4] = 2'd0; expDataSeq[4] = 8'h0E;

      // Reset state.
      rst = 1'b1;
      applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_data", 32'(res_data), 32'd0);
      checkOutput("rst_id", 32'(res_id), 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle_noreq_gnt", 32'(gnt), 32'd0);
      checkOutput("idle_noreq_busy", 32'(busy), 32'd0);

      // Single request: A5 ^ 3C = 99 from requester 0.
      runOne("single", 4'b0001, 32'h0000_00A5, 32'h0000_003C, 4'b0001, 8'h99, 2'd0);

      // Edge operands: FF ^ FF = 00 (req 0), 00 ^ FF = FF (req 2).
      runOne("edgeFF", 4'b0001, 32'h0000_00FF, 32'h0000_00FF, 4'b0001, 8'h00, 2'd0);
      runOne("edge00", 4'b0100, 32'h0000_0000, 32'h00FF_0000, 4'b0100, 8'hFF, 2'd2);

      // Backpressure on requester 3: 12 ^ 34 = 26. Operand A changes and
      // ready pulses during SHIFT; neither may disturb the transaction.
      applyStimulus(4'b1000, 32'h1200_0000, 32'h3400_0000, 1'b0);
      checkOutput("bp_gnt", 32'(gnt), 32'b1000);
      tick();
      applyStimulus(4'b0000, 32'h1200_0000, 32'h3400_0000, 1'b0);
      tick();
      applyStimulus(4'b0000, 32'hFF00_0000, 32'h3400_0000, 1'b1);
      checkOutput("bp_readyShift_busy", 32'(busy), 32'd1);
      tick();
      applyStimulus(4'b0000, 32'hFF00_0000, 32'h3400_0000, 1'b0);
      repeat (6) tick();
      checkOutput("bp_valid0", 32'(res_valid), 32'd1);
      checkOutput("bp_data0", 32'(res_data), 32'h26);
      checkOutput("bp_id0", 32'(res_id), 32'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_validHold", 32'(res_valid), 32'd1);
         checkOutput("bp_dataHold", 32'(res_data), 32'h26);
         checkOutput("bp_idHold", 32'(res_id), 32'd3);
         checkOutput("bp_busyHold", 32'(busy), 32'd1);
      end
      applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
      tick();
      checkOutput("bp_validAfter", 32'(res_valid), 32'd0);
      checkOutput("bp_busyAfter", 32'(busy), 32'd0);

      // All requesting: pointer sits on 3, so grants go 0,1,2,3,0 ten
      // cycles apart. Results: 0F^01, F0^33, 55^0F, 81^7E.
      applyStimulus(4'b1111, 32'h8155_F00F, 32'h7E0F_3301, 1'b1);
      for (int g = 0; g < 5; g++) begin
         checkOutput("all_gnt", 32'(gnt), 32'(expGntSeq[g]));
         tick();
         if (g == 4) begin
            applyStimulus(4'b0000, 32'h8155_F00F, 32'h7E0F_3301, 1'b1);
         end
         checkOutput("all_gntT1", 32'(gnt), 32'd0);
         repeat (7) tick();
         checkOutput("all_validT8", 32'(res_valid), 32'd0);
         tick();
         checkOutput("all_validT9", 32'(res_valid), 32'd1);
         checkOutput("all_id", 32'(res_id), 32'(expIdSeq[g]));
         checkOutput("all_data", 32'(res_data), 32'(expDataSeq[g]));
         tick();
      end
      checkOutput("all_idleAfter", 32'(busy), 32'd0);

      // Late arrival: requester 1 rises while 0 is served (5A^0F=55) and
      // is granted only once the block is back in IDLE (C3^3C=FF).
      applyStimulus(4'b0001, 32'h0000_C35A, 32'h0000_3C0F, 1'b1);
      checkOutput("late_gnt0", 32'(gnt), 32'b0001);
      tick();
      applyStimulus(4'b0010, 32'h0000_C35A, 32'h0000_3C0F, 1'b1);
      checkOutput("late_gntT1", 32'(gnt), 32'd0);
      tick();
      tick();
      checkOutput("late_gntT3", 32'(gnt), 32'd0);
      repeat (6) tick();
      checkOutput("late_gntT9", 32'(gnt), 32'd0);
      checkOutput("late_valid0", 32'(res_valid), 32'd1);
      checkOutput("late_data0", 32'(res_data), 32'h55);
      checkOutput("late_id0", 32'(res_id), 32'd0);
      tick();
      checkOutput("late_gnt1", 32'(gnt), 32'b0010);
      tick();
      applyStimulus(4'b0000, 32'h0000_C35A, 32'h0000_3C0F, 1'b1);
      checkOutput("late_gnt1T1", 32'(gnt), 32'd0);
      repeat (8) tick();
      checkOutput("late_valid1", 32'(res_valid), 32'd1);
      checkOutput("late_data1", 32'(res_data), 32'hFF);
      checkOutput("late_id1", 32'(res_id), 32'd1);
      tick();

      // Reset mid-SHIFT: requester 2 granted, reset in cycle T+4.
      applyStimulus(4'b0100, 32'h0011_0000, 32'h0022_0000, 1'b1);
      checkOutput("rmid_gnt", 32'(gnt), 32'b0100);
      tick();
      applyStimulus(4'b0000, 32'h0011_0000, 32'h0022_0000, 1'b1);
      repeat (3) tick();
      checkOutput("rmid_busyT4", 32'(busy), 32'd1);
      rst = 1'b1;
      applyStimulus(4'b1111, 32'h0011_0000, 32'h0022_0000, 1'b1);
      checkOutput("rmid_gnt", 32'(gnt), 32'd0);
      checkOutput("rmid_busy", 32'(busy), 32'd0);
      checkOutput("rmid_valid", 32'(res_valid), 32'd0);
      checkOutput("rmid_data", 32'(res_data), 32'd0);
      checkOutput("rmid_id", 32'(res_id), 32'd0);
      tick();
      applyStimulus(4'b0000, 32'h0011_0000, 32'h0022_0000, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("rmid_noValid", 32'(res_valid), 32'd0);
      end
      applyStimulus(4'b1111, 32'h0011_0000, 32'h0022_0000, 1'b1);
      checkOutput("rmid_nextGnt", 32'(gnt), 32'b0001);
      tick();
      applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
